// File: rtl/flash_uart_pkg.sv
// rtl/flash_uart_pkg.sv - shared macro-state codes, geometry defaults and sequencer states
// Imported by the sequencer, the command issuer and both engines so that every
// block agrees on the 4-bit macro-state encoding.
package flash_uart_pkg;

    // UART engine codes
    localparam logic [3:0] MS_SET_UART_MENU   = 4'h1;
    localparam logic [3:0] MS_SET_UART_ADDR   = 4'h2;
    localparam logic [3:0] MS_SET_UART_DATA   = 4'h3;
    localparam logic [3:0] MS_SEND_UART_NEWLN = 4'h4;
    localparam logic [3:0] MS_WAIT_UART_MSG   = 4'h5;
    localparam logic [3:0] MS_SET_UART_RDFL   = 4'h6;
    localparam logic [3:0] MS_BUFF_UART       = 4'h7;

    // Flash engine codes
    localparam logic [3:0] MS_FLASH_ERS4KB    = 4'hA;
    localparam logic [3:0] MS_FLASH_RDID      = 4'hB;
    localparam logic [3:0] MS_FLASH_WRPG      = 4'hC;
    localparam logic [3:0] MS_FLASH_RDPG      = 4'hD;

    localparam int unsigned SECTOR_BYTES_DEFAULT = 4096;
    localparam int unsigned PAGE_BYTES_DEFAULT   = 256;

    // MENU_ISSUE..RDID name the step whose command is in flight; ST_ISSUE and
    // ST_WAIT are the shared issue/wait sub-phase that keeps the step in ret_state.
    typedef enum logic [3:0] {
        RST_IDLE, MENU_ISSUE, SEL_WAIT, ADDR_Q, ADDR_W, LEN_Q, LEN_W,
        FILE_Q, BUFF, ERASE, PAGE, NEWLN, RDID, ST_ISSUE, ST_WAIT
    } seq_state_t;

    function automatic logic is_uart_code(input logic [3:0] code);
        return (code >= MS_SET_UART_MENU) && (code <= MS_BUFF_UART);
    endfunction

    function automatic logic is_flash_code(input logic [3:0] code);
        return code >= MS_FLASH_ERS4KB;
    endfunction

endpackage

// File: rtl/macro_cmd_issuer.sv
// rtl/macro_cmd_issuer.sv - strobes one macro-state code and waits for its engine's done
// Ports: clk/rst (sync, active high); start+code request an issue; macro_states
// holds the code until completion; macro_states_valid is the 1-cycle strobe;
// uart_done/flash_done are engine pulses; cmd_done is the combinational
// completion pulse returned to the sequencer.
module macro_cmd_issuer
    import flash_uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] code,
    input  logic       uart_done,
    input  logic       flash_done,
    output logic [3:0] macro_states,
    output logic       macro_states_valid,
    output logic       cmd_done
);

    logic waiting;
    logic done_sel;

    // Only the engine that owns the code can complete it; a done arriving
    // while the strobe is still high belongs to no command of ours.
    always_comb begin
        done_sel = 1'b0;
        if (is_uart_code(macro_states))
            done_sel = uart_done;
        else if (is_flash_code(macro_states))
            done_sel = flash_done;
        cmd_done = waiting && !macro_states_valid && done_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            macro_states       <= 4'h0;
            macro_states_valid <= 1'b0;
            waiting            <= 1'b0;
        end else if (start) begin
            macro_states       <= code;
            macro_states_valid <= 1'b1;
            waiting            <= 1'b1;
        end else begin
            macro_states_valid <= 1'b0;
            if (cmd_done) begin
                macro_states <= 4'h0;
                waiting      <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/flash_menu_sequencer.sv
// rtl/flash_menu_sequencer.sv - menu / erase / program / read sequencer for the QSPI programmer
// Ports: clk/rst (sync, active high); macro_states + macro_states_valid drive the
// engines; uart_done/flash_done complete commands; rx_num is the user's hex entry;
// rx_cnt, flash_addr, flash_nbytes are command operands; busy flags an operation.
module flash_menu_sequencer
    import flash_uart_pkg::*;
#(
    parameter int unsigned SECTOR_BYTES = SECTOR_BYTES_DEFAULT,
    parameter int unsigned PAGE_BYTES   = PAGE_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  macro_states,
    output logic        macro_states_valid,
    input  logic        uart_done,
    input  logic        flash_done,
    input  logic [31:0] rx_num,
    output logic [15:0] rx_cnt,
    output logic [31:0] flash_addr,
    output logic [8:0]  flash_nbytes,
    output logic        busy
);

    localparam logic [31:0] SECTOR_MASK = 32'(SECTOR_BYTES - 1);
    localparam logic [31:0] PAGE_MASK   = 32'(PAGE_BYTES - 1);

    seq_state_t  state, ret_state;
    logic        cmd_start, cmd_done;
    logic [3:0]  cmd_code, sel;
    logic [31:0] addr, remain, cur_addr, sec_left;
    logic [32:0] erase_end;
    logic [31:0] cur_next, remain_next, sec_next;
    logic [32:0] erase_next;

    // Bytes to the end of the page holding a, capped at limit.
    function automatic logic [31:0] page_chunk(input logic [31:0] a, input logic [31:0] limit);
        logic [31:0] room;
        room = 32'(PAGE_BYTES) - (a & PAGE_MASK);
        return (limit < room) ? limit : room;
    endfunction

    function automatic logic [31:0] sector_chunk(input logic [31:0] left);
        return (left < 32'(SECTOR_BYTES)) ? left : 32'(SECTOR_BYTES);
    endfunction

    always_comb begin
        cur_next    = cur_addr + 32'(flash_nbytes);
        remain_next = remain - 32'(flash_nbytes);
        sec_next    = sec_left - 32'(flash_nbytes);
        erase_next  = {1'b0, flash_addr} + 33'(SECTOR_BYTES);
    end

    assign busy = !(ret_state inside {RST_IDLE, MENU_ISSUE, SEL_WAIT});

    macro_cmd_issuer u_issuer (
        .clk                (clk),
        .rst                (rst),
        .start              (cmd_start),
        .code               (cmd_code),
        .uart_done          (uart_done),
        .flash_done         (flash_done),
        .macro_states       (macro_states),
        .macro_states_valid (macro_states_valid),
        .cmd_done           (cmd_done)
    );

    // Completion is handled in the same edge as cmd_done so operands are
    // registered one cycle ahead of the strobe the issuer raises next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RST_IDLE;
            ret_state    <= RST_IDLE;
            cmd_start    <= 1'b0;
            cmd_code     <= 4'h0;
            sel          <= 4'h0;
            addr         <= '0;
            remain       <= '0;
            cur_addr     <= '0;
            sec_left     <= '0;
            erase_end    <= '0;
            rx_cnt       <= '0;
            flash_addr   <= '0;
            flash_nbytes <= '0;
        end else begin
            cmd_start <= 1'b0;
            case (state)
                RST_IDLE: begin
                    cmd_start <= 1'b1;
                    cmd_code  <= MS_SET_UART_MENU;
                    ret_state <= MENU_ISSUE;
                    state     <= ST_ISSUE;
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: if (cmd_done) begin
                    cmd_start <= 1'b1;
                    state     <= ST_ISSUE;
                    case (ret_state)
                        MENU_ISSUE: begin cmd_code <= MS_WAIT_UART_MSG; ret_state <= SEL_WAIT; end
                        SEL_WAIT: begin
                            sel <= rx_num[3:0];
                            if (rx_num[3:0] == 4'd1) begin
                                cmd_code <= MS_FLASH_RDID; ret_state <= RDID;
                            end else if (rx_num[3:0] >= 4'd2 && rx_num[3:0] <= 4'd5) begin
                                cmd_code <= MS_SET_UART_ADDR; ret_state <= ADDR_Q;
                            end else begin
                                cmd_code <= MS_SEND_UART_NEWLN; ret_state <= NEWLN;
                            end
                        end
                        ADDR_Q: begin cmd_code <= MS_WAIT_UART_MSG; ret_state <= ADDR_W; end
                        ADDR_W: begin
                            addr     <= rx_num;
                            cmd_code <= MS_SET_UART_DATA; ret_state <= LEN_Q;
                        end
                        LEN_Q: begin cmd_code <= MS_WAIT_UART_MSG; ret_state <= LEN_W; end
                        LEN_W: begin
                            remain   <= rx_num;
                            cur_addr <= addr;
                            if (rx_num == 32'd0) begin
                                cmd_code <= MS_SEND_UART_NEWLN; ret_state <= NEWLN;
                            end else if (sel == 4'd2) begin
                                flash_addr <= addr & ~SECTOR_MASK;
                                erase_end  <= {1'b0, addr} + {1'b0, rx_num};
                                cmd_code   <= MS_FLASH_ERS4KB; ret_state <= ERASE;
                            end else if (sel == 4'd4) begin
                                cmd_code <= MS_SET_UART_RDFL; ret_state <= FILE_Q;
                            end else begin
                                flash_addr   <= addr;
                                flash_nbytes <= 9'(page_chunk(addr, rx_num));
                                cmd_code     <= MS_FLASH_RDPG; ret_state <= PAGE;
                            end
                        end
                        FILE_Q: begin
                            rx_cnt   <= 16'(sector_chunk(remain));
                            sec_left <= sector_chunk(remain);
                            cmd_code <= MS_BUFF_UART; ret_state <= BUFF;
                        end
                        BUFF: begin
                            flash_addr <= cur_addr & ~SECTOR_MASK;
                            cmd_code   <= MS_FLASH_ERS4KB; ret_state <= ERASE;
                        end
                        ERASE: begin
                            if (sel == 4'd4) begin
                                flash_addr   <= cur_addr;
                                flash_nbytes <= 9'(page_chunk(cur_addr, sec_left));
                                cmd_code     <= MS_FLASH_WRPG; ret_state <= PAGE;
                            end else if (erase_next >= erase_end) begin
                                cmd_code <= MS_SEND_UART_NEWLN; ret_state <= NEWLN;
                            end else begin
                                flash_addr <= erase_next[31:0];
                                cmd_code   <= MS_FLASH_ERS4KB; ret_state <= ERASE;
                            end
                        end
                        PAGE: begin
                            cur_addr <= cur_next;
                            remain   <= remain_next;
                            sec_left <= sec_next;
                            if (sel == 4'd4 && sec_next != 32'd0) begin
                                flash_addr   <= cur_next;
                                flash_nbytes <= 9'(page_chunk(cur_next, sec_next));
                                cmd_code     <= MS_FLASH_WRPG; ret_state <= PAGE;
                            end else if (remain_next == 32'd0) begin
                                cmd_code <= MS_SEND_UART_NEWLN; ret_state <= NEWLN;
                            end else if (sel == 4'd4) begin
                                rx_cnt   <= 16'(sector_chunk(remain_next));
                                sec_left <= sector_chunk(remain_next);
                                cmd_code <= MS_BUFF_UART; ret_state <= BUFF;
                            end else begin
                                flash_addr   <= cur_next;
                                flash_nbytes <= 9'(page_chunk(cur_next, remain_next));
                                cmd_code     <= MS_FLASH_RDPG; ret_state <= PAGE;
                            end
                        end
                        RDID: begin cmd_code <= MS_SEND_UART_NEWLN; ret_state <= NEWLN; end
                        NEWLN: begin cmd_code <= MS_SET_UART_MENU; ret_state <= MENU_ISSUE; end
                        default: begin
                            cmd_start <= 1'b0;
                            state     <= RST_IDLE;
                        end
                    endcase
                end
                default: state <= RST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/flash_menu_sequencer.md
# flash_menu_sequencer

Top-level sequencer for the UART QSPI-flash programmer. It drives the shared 4-bit macro-state bus that feeds the UART communication engine (codes 0x1–0x7) and the QSPI flash engine (codes 0xA–0xF). It presents the menu, collects the user's selection, address and length, and then steps through erase, program and read operations in 4 KiB sectors and 256-byte pages. It waits for each engine's done pulse before it issues the next code.

## Interface
- `SECTOR_BYTES`, 4096: erase and file-buffer granule in bytes. Must be a power of two.
- `PAGE_BYTES`, 256: flash page size in bytes. Must be a power of two.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `macro_states` out 4: code of the command being issued.
- `macro_states_valid` out 1: single-cycle strobe that marks `macro_states` as valid.
- `uart_done` in 1: one-cycle completion pulse from the UART engine.
- `flash_done` in 1: one-cycle completion pulse from the flash engine.
- `rx_num` in 32: hex value captured by the UART engine. Valid when `uart_done` follows a WaitUARTMsg command.
- `rx_cnt` out 16: byte count for BuffUART. Held stable from the strobe until done.
- `flash_addr` out 32: byte address for the current flash command.
- `flash_nbytes` out 9: byte count for FlashWrPg / FlashRdPg, range 1..256.
- `busy` out 1: high whenever the sequencer is outside MENU_ISSUE/SEL_WAIT.

## Operation
- **Issue/wait primitive.**
  - ISSUE: drive `macro_states`, pulse valid for exactly 1 cycle, then enter WAIT.
  - In WAIT, codes 0x1–0x7 complete on `uart_done`; codes 0xA–0xF complete on `flash_done`. The done signal of the other engine is ignored.
  - `macro_states` stays at the issued code until done, then returns to 0.
  - A done pulse in the issue cycle is ignored.
- **Menu.** Issue SetUARTMenu (0x1), then WaitUARTMsg (0x5). The selection is `sel = rx_num[3:0]`.
  - sel 1: FlashRdID (0xB) → NewLn → menu.
  - sel 2, 3, 4 or 5: address/length entry (below).
  - Any other value: SendUARTNewLn (0x4) → menu. No flash traffic.
- **Address/length entry.**
  - SetUARTAddr (0x2), WaitUARTMsg → `addr`.
  - SetUARTData (0x3), WaitUARTMsg → `remain` = `rx_num`.
  - If `remain` == 0, go directly to NewLn → menu.
- **sel 2 (erase).**
  - Sector base = `addr` with the low log2(SECTOR_BYTES) bits cleared.
  - Loop FlashERS4kB (0xA) at the sector base. Advance the base by SECTOR_BYTES until it is ≥ `addr`+`remain`. Compute the end in 33 bits, so no wrap.
- **sel 3 / sel 5 (blank check / read).**
  - Loop FlashRdPg (0xD). `flash_nbytes` = min(PAGE_BYTES − (`flash_addr` mod PAGE_BYTES), `remain`).
  - After each page: `flash_addr` += `flash_nbytes`, `remain` −= `flash_nbytes`, until `remain` == 0.
- **sel 4 (program).**
  - Issue SetUARTRdFl (0x6) once.
  - Per sector:
    - BuffUART (0x7) with `rx_cnt` = min(SECTOR_BYTES, `remain`).
    - FlashERS4kB at the aligned sector base.
    - Page loop of FlashWrPg (0xC) using the same `flash_nbytes` rule, covering `rx_cnt` bytes.
  - Repeat until `remain` == 0. `addr` is assumed sector-aligned for sel 4; low bits are used as-is for the page split.
- Every operation path ends with SendUARTNewLn and then returns to the menu.
- **Arithmetic.**
  - `remain` is unsigned 32-bit and never underflows, because the subtracted amount is always ≤ `remain`.
  - `flash_addr` wraps modulo 2^32.
- **States.** RST_IDLE, MENU_ISSUE, SEL_WAIT, ADDR_Q, ADDR_W, LEN_Q, LEN_W, FILE_Q, BUFF, ERASE, PAGE, NEWLN, plus the shared ISSUE/WAIT sub-phase. ISSUE/WAIT is implemented as a return-state register.
- **Unknown state:** recover to RST_IDLE.

## Timing
- Reset values: `macro_states`=0, `macro_states_valid`=0, `rx_cnt`=0, `flash_addr`=0, `flash_nbytes`=0, `busy`=0, state RST_IDLE.
- The first SetUARTMenu strobe is issued 2 cycles after `rst` deasserts.
- Latency from the done pulse to the next strobe is exactly 2 cycles. Operands (`rx_cnt`, `flash_addr`, `flash_nbytes`) are registered 1 cycle before their strobe.
- `rx_num` is sampled in the same cycle as `uart_done`.
- `rst` asserted mid-operation aborts immediately. No completion is awaited, and the next strobe after release is SetUARTMenu.

## Structure
- Shared package `flash_uart_pkg`:
  - macro-state code constants (0x1–0x7, 0xA–0xF);
  - SECTOR_BYTES / PAGE_BYTES defaults;
  - sequencer state enum.
  - The UART and flash engines import the same package.
- One natural sub-module: `macro_cmd_issuer`. It holds the strobe generation, code hold, and engine-select done wait, and returns a `cmd_done` pulse.

## Test plan
- Reset release, `uart_done` 2 cycles after each strobe, `rx_num`=1 → strobes 0x1, 0x5, 0xB, 0x4, 0x1. `flash_done` is awaited for 0xB.
- sel 2, addr 0x00001800, len 0x2000 → FlashERS4kB at 0x1000, 0x2000 and 0x3000 (3 erases), then 0x4.
- sel 5, addr 0x000000F0, len 0x120 → FlashRdPg pairs (0xF0, 16), (0x100, 256), (0x200, 16).
- sel 4, addr 0x10000, len 0x1100 → BuffUART `rx_cnt`=4096, erase 0x10000, 16 page writes; then BuffUART `rx_cnt`=256, erase 0x11000, 1 page write; then 0x4.
- sel 0x9, and len 0 with sel 3 → only 0x4 issued, no flash codes. A `flash_done` pulse during a UART wait must not advance the sequencer.
- `rst` pulsed while waiting on a FlashWrPg → all outputs return to 0, and the next strobe is 0x1 two cycles after release.
